// File: rtl/l2_mem_arbiter.sv
// Shared line-refill/write-back arbiter: serialises NUM_CH cache memory ports onto one downstream port.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest channel index wins).
//
// state | meaning
// IDLE  | bus free, arbitrating among requesting channels
// BUSY  | transaction latched on mem_*, waiting for mem_ready
// DONE  | one-cycle req_ready pulse to the granted channel
module l2_mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req_read,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]          req_rdata,
  output logic [NUM_CH-1:0]          req_ready,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0] req_any;
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              sel_wr;

  assign req_any = req_read | req_write;

`ifdef ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Search begins one past the last grant so every requester is reached within NUM_CH grants.
  always_comb begin
    int                idx;
    logic [NUM_CH-1:0] rot;
    idx     = 0;
    rot     = '0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      rot = req_any >> idx;
      if (!win_vld && rot[0]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= ID_W'(NUM_CH - 1);
    end else if (state == IDLE && win_vld) begin
      rr_ptr <= win_id;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_any[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end
`endif

  // A simultaneous read and write on one channel is treated as a write.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*LINE_W +: LINE_W];
        sel_wr    = req_write[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_rdata <= '0;
      req_ready <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_wr;
            mem_read  <= !sel_wr;
            grant_id  <= win_id;
            busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (mem_read) req_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            req_ready <= NUM_CH'(1) << grant_id;
          end
        end
        DONE: begin
          req_ready <= '0;
          busy      <= 1'b0;
        end
        default: begin
          req_ready <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: transaction-level model compared every cycle plus literal pins.
// Expectations follow ARB_RR_EN the same way the design does.
module tb_l2_mem_arbiter;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
  localparam int ID_W   = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        req_read, req_write, req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]        req_rdata, mem_wdata, mem_rdata;
  logic                     mem_read, mem_write, mem_ready, busy;
  logic [ADDR_W-1:0]        mem_addr;
  logic [ID_W-1:0]          grant_id;

  l2_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_id(grant_id), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Downstream memory: answers mem_lat cycles after a request appears.
  int           mem_lat = 1;
  logic [127:0] rdata_val = '0;
  bit           force_rdy = 1'b0;
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (force_rdy) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_val;
      end else if ((mem_read || mem_write) && !mem_ready) begin
        if (cnt == mem_lat - 1) begin
          mem_ready = 1'b1;
          mem_rdata = rdata_val;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Model: one outstanding transaction, a one-cycle completion pulse, then the bus is free again.
  logic [1:0]   e_ready;
  logic         e_mrd, e_mwr, e_busy;
  logic [27:0]  e_addr;
  logic [127:0] e_wdata, e_rdata;
  logic [0:0]   e_gid;
  bit           txn_open, pulse;
`ifdef ARB_RR_EN
  int           last_gid;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ready = '0; e_mrd = 0; e_mwr = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_gid = '0;
      txn_open = 0; pulse = 0;
`ifdef ARB_RR_EN
      last_gid = NUM_CH - 1;
`endif
    end else if (pulse) begin
      pulse = 0;
      e_ready = '0;
      e_busy = 0;
    end else if (txn_open) begin
      if (mem_ready) begin
        if (e_mrd) e_rdata = mem_rdata;
        e_mrd = 0;
        e_mwr = 0;
        e_ready = '0;
        e_ready[e_gid] = 1'b1;
        pulse = 1;
        txn_open = 0;
      end
    end else begin
      int w;
      w = -1;
`ifdef ARB_RR_EN
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (last_gid + k) % NUM_CH;
        if (w < 0 && (req_read[c] || req_write[c])) w = c;
      end
`else
      for (int c = 0; c < NUM_CH; c++)
        if (w < 0 && (req_read[c] || req_write[c])) w = c;
`endif
      if (w >= 0) begin
        e_gid   = 1'(w);
        e_addr  = req_addr[w*ADDR_W +: ADDR_W];
        e_wdata = req_wdata[w*LINE_W +: LINE_W];
        e_mwr   = req_write[w];
        e_mrd   = !req_write[w];
        e_busy  = 1;
        txn_open = 1;
`ifdef ARB_RR_EN
        last_gid = w;
`endif
      end
    end
  end

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    cmp("req_ready", 128'(req_ready), 128'(e_ready));
    cmp("req_rdata", req_rdata, e_rdata);
    cmp("mem_read", 128'(mem_read), 128'(e_mrd));
    cmp("mem_write", 128'(mem_write), 128'(e_mwr));
    cmp("mem_addr", 128'(mem_addr), 128'(e_addr));
    cmp("mem_wdata", mem_wdata, e_wdata);
    cmp("grant_id", 128'(grant_id), 128'(e_gid));
    cmp("busy", 128'(busy), 128'(e_busy));
  endtask

  task automatic half_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    half_neg();
    to_pos();
  endtask

  logic [1:0]   hit_ready;
  logic [127:0] hit_rdata;
  logic         hit_mrd;
  int           hit_n;

  task automatic wait_ready(input logic [1:0] mask, input int budget);
    hit_n = 0;
    hit_ready = '0;
    hit_rdata = '0;
    hit_mrd = 1'b0;
    while (1) begin
      half_neg();
      hit_n++;
      if ((req_ready & mask) != 2'b00) begin
        hit_ready = req_ready;
        hit_rdata = req_rdata;
        hit_mrd   = mem_read;
        to_pos();
        return;
      end
      if (hit_n >= budget) begin
        n_checks++;
        n_errors++;
        $display("FAIL ready_timeout: no req_ready within %0d cycles, required mask %b", budget, mask);
        to_pos();
        return;
      end
      to_pos();
    end
  endtask

  localparam logic [127:0] WD0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] WD1 = 128'hFEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D;
  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] RD_C0 = {4{32'hC0DE_0001}};

  logic [1:0] exp_seq [4];

  initial begin
`ifdef ARB_RR_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
    rst_n = 1'b0;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) step();
    cmp("rst_busy", 128'(busy), 128'd0);
    cmp("rst_ready", 128'(req_ready), 128'd0);
    cmp("rst_grant", 128'(grant_id), 128'd0);
    rst_n = 1'b1;
    step();

    // Single read on channel 1, memory answers after 5 cycles.
    req_addr[ADDR_W +: ADDR_W] = 28'h0000123;
    mem_lat = 5;
    rdata_val = RD_A5;
    req_read = 2'b10;
    step();
    cmp("t1_mem_read", 128'(mem_read), 128'd1);
    cmp("t1_mem_addr", 128'(mem_addr), 128'h0000123);
    cmp("t1_grant", 128'(grant_id), 128'd1);
    wait_ready(2'b10, 20);
    cmp("t1_latency", 128'(hit_n), 128'd6);
    cmp("t1_ready", 128'(hit_ready), 128'b10);
    cmp("t1_rdata", hit_rdata, RD_A5);
    cmp("t1_mrd_done", 128'(hit_mrd), 128'd0);
    req_read = 2'b00;
    cmp("t1_idle_busy", 128'(busy), 128'd0);
    step();

    // Write on channel 0; read data bus keeps its value.
    req_wdata[0 +: LINE_W] = WD0;
    mem_lat = 1;
    rdata_val = '1;
    req_write = 2'b01;
    step();
    cmp("t2_mem_write", 128'(mem_write), 128'd1);
    cmp("t2_mem_read", 128'(mem_read), 128'd0);
    cmp("t2_wdata", mem_wdata, WD0);
    wait_ready(2'b01, 10);
    cmp("t2_latency", 128'(hit_n), 128'd2);
    cmp("t2_ready", 128'(hit_ready), 128'b01);
    cmp("t2_rdata_kept", hit_rdata, RD_A5);
    req_write = 2'b00;
    repeat (2) step();

    // Both channels request continuously from a fresh reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req_addr = {28'h0BBB_BBB, 28'h0AAA_AAA};
    rdata_val = RD_A5;
    req_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ready(2'b11, 10);
      cmp($sformatf("t3_grant_%0d", i), 128'(hit_ready), 128'(exp_seq[i]));
    end
    req_read = 2'b10;
    wait_ready(2'b10, 10);
    cmp("t3_ch1_after", 128'(hit_ready), 128'b10);
    req_read = 2'b00;
    step();

    // Channel 0 withdraws during BUSY; transaction still completes, no reissue.
    mem_lat = 3;
    req_read = 2'b01;
    step();
    req_read = 2'b00;
    wait_ready(2'b01, 10);
    cmp("t4_ready", 128'(hit_ready), 128'b01);
    repeat (4) step();
    cmp("t4_busy", 128'(busy), 128'd0);
    cmp("t4_mem_read", 128'(mem_read), 128'd0);

    // Reset during BUSY abandons the transaction; channel 0 wins afterwards.
    mem_lat = 4;
    rdata_val = RD_C0;
    req_read = 2'b11;
    step();
    step();
    rst_n = 1'b0;
    #1;
    cmp("t5_rst_mem_read", 128'(mem_read), 128'd0);
    cmp("t5_rst_busy", 128'(busy), 128'd0);
    cmp("t5_rst_addr", 128'(mem_addr), 128'd0);
    cmp("t5_rst_grant", 128'(grant_id), 128'd0);
    step();
    rst_n = 1'b1;
    wait_ready(2'b11, 20);
    cmp("t5_first", 128'(hit_ready), 128'b01);
    req_read = 2'b10;
    wait_ready(2'b10, 20);
    cmp("t5_second", 128'(hit_ready), 128'b10);
    req_read = 2'b00;
    step();

    // Read and write together on channel 1 is a write.
    req_wdata[LINE_W +: LINE_W] = WD1;
    mem_lat = 2;
    rdata_val = '1;
    req_read = 2'b10;
    req_write = 2'b10;
    step();
    cmp("t6_mem_write", 128'(mem_write), 128'd1);
    cmp("t6_mem_read", 128'(mem_read), 128'd0);
    cmp("t6_wdata", mem_wdata, WD1);
    wait_ready(2'b10, 10);
    cmp("t6_ready", 128'(hit_ready), 128'b10);
    req_read = 2'b00;
    req_write = 2'b00;
    step();

    // Stray mem_ready while idle is ignored.
    force_rdy = 1'b1;
    repeat (3) step();
    force_rdy = 1'b0;
    step();
    cmp("t7_busy", 128'(busy), 128'd0);
    cmp("t7_ready", 128'(req_ready), 128'd0);
    cmp("t7_rdata", req_rdata, RD_C0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
